onehot_regfile: RTL and testbench

- Register file that sits directly downstream of the operand select decoders (rs/rt/rd one-hot decoders).
- Consumes three one-hot select vectors:
  - Aselect: read port A.
  - Bselect: read port B.
  - Dselect: write port D.
- Holds NREGS general registers and presents registered read data to the execute stage one cycle after the selects are applied.
- Register 0 is hardwired to zero. Malformed (non-one-hot) selects are flagged rather than silently OR-ing registers together.

---
 rtl/onehot_regfile_pkg.sv | 12 +
 rtl/onehot_regfile_check.sv | 26 ++
 rtl/onehot_regfile.sv | 94 +++++++++
 tb/tb_onehot_regfile.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/onehot_regfile_pkg.sv
// Shared defaults and index-width helper for the one-hot register file.
package onehot_regfile_pkg;

   localparam int WIDTH_DEFAULT = 32;
   localparam int NREGS_DEFAULT = 32;

   // Binary index width for an n-entry one-hot vector (at least 1 bit).
   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/onehot_regfile_check.sv
// One-hot checker: flags exactly-one-bit-set and encodes the set bit's index.
module onehot_check
   import onehot_regfile_pkg::*;
#(
   parameter int N  = NREGS_DEFAULT,
   parameter int IW = idx_width(N)
) (
   input  logic [N-1:0]  vec,
   output logic          valid,
   output logic [IW-1:0] idx
);

   // Exactly one bit set: non-zero and clearing the lowest set bit leaves zero.
   assign valid = (vec != '0) && ((vec & (vec - 1'b1)) == '0);

   // OR-encode the set bit positions; only meaningful when valid is high.
   always_comb begin
      idx = '0;
      for (int i = 0; i < N; i++) begin
         if (vec[i]) begin
            idx = idx | i[IW-1:0];
         end
      end
   end

endmodule

// File: rtl/onehot_regfile.sv
// Register file addressed by one-hot selects: two registered read ports with
// write-through bypass, one write port, register 0 hardwired to zero, and
// malformed-select detection.
module onehot_regfile
   import onehot_regfile_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEFAULT,
   parameter int NREGS = NREGS_DEFAULT
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [NREGS-1:0] Aselect,
   input  logic [NREGS-1:0] Bselect,
   input  logic [NREGS-1:0] Dselect,
   input  logic             we,
   input  logic [WIDTH-1:0] dbus,
   output logic [WIDTH-1:0] abus,
   output logic [WIDTH-1:0] bbus,
   output logic             sel_err,
   output logic             sel_err_sticky
);

   localparam int IW = idx_width(NREGS);

   logic          a_valid, b_valid, d_valid;
   logic [IW-1:0] a_idx, b_idx, d_idx;

   logic [WIDTH-1:0] regs [NREGS];
   logic [WIDTH-1:0] a_value, b_value;
   logic             wr_bypass;
   logic             sel_err_next;

   onehot_check #(.N(NREGS), .IW(IW)) u_check_a (.vec(Aselect), .valid(a_valid), .idx(a_idx));
   onehot_check #(.N(NREGS), .IW(IW)) u_check_b (.vec(Bselect), .valid(b_valid), .idx(b_idx));
   onehot_check #(.N(NREGS), .IW(IW)) u_check_d (.vec(Dselect), .valid(d_valid), .idx(d_idx));

   // Register storage: entry 0 is a constant zero, the rest are written when
   // the write select is a valid one-hot hitting that entry. The per-register
   // enable uses the raw select bit since d_valid already guarantees one-hot.
   genvar gi;
   generate
      for (gi = 0; gi < NREGS; gi++) begin : g_reg
         if (gi == 0) begin : g_zero
            assign regs[gi] = '0;
         end else begin : g_store
            // Clear on reset; capture dbus on a valid write to this entry.
            always_ff @(posedge clk or negedge rst_n) begin
               if (!rst_n) begin
                  regs[gi] <= '0;
               end else if (we && d_valid && Dselect[gi]) begin
                  regs[gi] <= dbus;
               end
            end
         end
      end
   endgenerate

   // A write is forwarded to readers only if it will actually land in storage.
   assign wr_bypass = we && d_valid && (d_idx != '0);

   // Read value selection: malformed or index-0 selects read zero, a select
   // matching the in-flight write sees dbus, otherwise the stored register.
   always_comb begin
      a_value = '0;
      if (a_valid && (a_idx != '0)) begin
         if (wr_bypass && (a_idx == d_idx)) a_value = dbus;
         else                               a_value = regs[a_idx];
      end
      b_value = '0;
      if (b_valid && (b_idx != '0)) begin
         if (wr_bypass && (b_idx == d_idx)) b_value = dbus;
         else                               b_value = regs[b_idx];
      end
   end

   // The write select only counts as malformed when a write is requested.
   assign sel_err_next = !a_valid || !b_valid || (we && !d_valid);

   // Output registers: read data and error flags, all cleared by reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         abus           <= '0;
         bbus           <= '0;
         sel_err        <= 1'b0;
         sel_err_sticky <= 1'b0;
      end else begin
         abus           <= a_value;
         bbus           <= b_value;
         sel_err        <= sel_err_next;
         sel_err_sticky <= sel_err_sticky | sel_err_next;
      end
   end

endmodule

// File: tb/tb_onehot_regfile.sv
// Directed self-checking bench for onehot_regfile with hand-computed values.
module tb_onehot_regfile;

   localparam int WIDTH = 32;
   localparam int NREGS = 32;

   logic             clk;
   logic             rst_n;
   logic [NREGS-1:0] Aselect;
   logic [NREGS-1:0] Bselect;
   logic [NREGS-1:0] Dselect;
   logic             we;
   logic [WIDTH-1:0] dbus;
   logic [WIDTH-1:0] abus;
   logic [WIDTH-1:0] bbus;
   logic             sel_err;
   logic             sel_err_sticky;

   int n_checks = 0;
   int n_fails  = 0;

   onehot_regfile #(.WIDTH(WIDTH), .NREGS(NREGS)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .Aselect        (Aselect),
      .Bselect        (Bselect),
      .Dselect        (Dselect),
      .we             (we),
      .dbus           (dbus),
      .abus           (abus),
      .bbus           (bbus),
      .sel_err        (sel_err),
      .sel_err_sticky (sel_err_sticky)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Single comparison point: counts every check, reports any mismatch.
   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fails++;
         $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
      end else begin
         $display("ok   %s: %08h", tag, obs);
      end
   endtask

   // Advance one rising edge and settle 1 time unit past it.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [NREGS-1:0] oh(input int i);
      logic [NREGS-1:0] v;
      v = '0;
      v[i] = 1'b1;
      return v;
   endfunction

   initial begin
      rst_n   = 1'b0;
      we      = 1'b0;
      dbus    = '0;
      Dselect = '0;
      Aselect = oh(5);
      Bselect = oh(31);

      // Reset then read
      step();
      step();
      check("rst_abus", abus, 32'h0);
      check("rst_bbus", bbus, 32'h0);
      check("rst_sel_err", {31'b0, sel_err}, 32'h0);
      check("rst_sticky", {31'b0, sel_err_sticky}, 32'h0);
      rst_n = 1'b1;
      step();
      check("post_rst_abus", abus, 32'h0);
      check("post_rst_sel_err", {31'b0, sel_err}, 32'h0);

      // Write then read
      we = 1'b1; Dselect = oh(3); dbus = 32'hDEADBEEF;
      step();
      we = 1'b0; Aselect = oh(3);
      step();
      check("wr3_rd_abus", abus, 32'hDEADBEEF);
      check("wr3_rd_bbus_r31", bbus, 32'h0);

      // Register 0 stays zero
      we = 1'b1; Dselect = oh(0); dbus = 32'hFFFFFFFF;
      step();
      we = 1'b0; Aselect = oh(0); Bselect = oh(0);
      step();
      check("r0_abus", abus, 32'h0);
      check("r0_bbus", bbus, 32'h0);
      check("r0_sel_err", {31'b0, sel_err}, 32'h0);

      // Bypass: reg7 old value 0x11111111, overwritten while being read
      we = 1'b1; Dselect = oh(7); dbus = 32'h11111111; Aselect = oh(3); Bselect = oh(3);
      step();
      dbus = 32'h22222222; Aselect = oh(7); Bselect = oh(7);
      step();
      check("byp_abus", abus, 32'h22222222);
      check("byp_bbus", bbus, 32'h22222222);
      we = 1'b0;
      step();
      check("byp_hold_abus", abus, 32'h22222222);
      check("byp_hold_bbus", bbus, 32'h22222222);

      // Malformed Aselect
      Aselect = 32'h00000006; Bselect = oh(3);
      step();
      check("mal_a_abus", abus, 32'h0);
      check("mal_a_bbus", bbus, 32'hDEADBEEF);
      check("mal_a_sel_err", {31'b0, sel_err}, 32'h1);
      check("mal_a_sticky", {31'b0, sel_err_sticky}, 32'h1);
      Aselect = oh(3);
      step();
      check("mal_a_pulse_end", {31'b0, sel_err}, 32'h0);
      check("mal_a_sticky_held", {31'b0, sel_err_sticky}, 32'h1);
      check("mal_a_recover_abus", abus, 32'hDEADBEEF);

      // Malformed write selects: all-zero then multi-hot over reg3 and reg7
      we = 1'b1; Dselect = 32'h00000000; dbus = 32'h12345678;
      step();
      check("mal_d0_sel_err", {31'b0, sel_err}, 32'h1);
      Dselect = oh(3) | oh(7);
      step();
      check("mal_dmh_sel_err", {31'b0, sel_err}, 32'h1);
      we = 1'b0; Dselect = '0; Aselect = oh(3); Bselect = oh(7);
      step();
      check("we0_d0_no_pulse", {31'b0, sel_err}, 32'h0);
      check("mal_d_r3_kept", abus, 32'hDEADBEEF);
      check("mal_d_r7_kept", bbus, 32'h22222222);

      // Consecutive malformed cycles give consecutive pulses (Bselect all-zero)
      Bselect = '0;
      step();
      check("consec_1", {31'b0, sel_err}, 32'h1);
      check("consec_1_bbus", bbus, 32'h0);
      step();
      check("consec_2", {31'b0, sel_err}, 32'h1);
      Bselect = oh(9);
      step();
      check("consec_end", {31'b0, sel_err}, 32'h0);

      // Async reset mid-operation
      we = 1'b1; Dselect = oh(9); dbus = 32'hCAFEF00D;
      step();
      we = 1'b0; Aselect = oh(9); Bselect = oh(9);
      step();
      check("r9_abus", abus, 32'hCAFEF00D);
      check("r9_bbus", bbus, 32'hCAFEF00D);
      #2;
      rst_n = 1'b0;
      #1;
      check("async_abus", abus, 32'h0);
      check("async_bbus", bbus, 32'h0);
      check("async_sticky", {31'b0, sel_err_sticky}, 32'h0);
      // Write attempted while reset is held must be discarded
      we = 1'b1; Dselect = oh(10); dbus = 32'hAAAA5555;
      step();
      we = 1'b0; rst_n = 1'b1; Aselect = oh(9); Bselect = oh(10);
      step();
      check("post_async_r9", abus, 32'h0);
      check("post_async_r10", bbus, 32'h0);
      Aselect = oh(3); Bselect = oh(7);
      step();
      check("post_async_r3", abus, 32'h0);
      check("post_async_r7", bbus, 32'h0);
      check("post_async_sticky", {31'b0, sel_err_sticky}, 32'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
